pipeline_piso: RTL and testbench

PIPELINE_PISO -- requirements
Module: pipeline_piso

---
 rtl/pipeline_piso.sv | 83 ++++++++
 tb/tb_pipeline_piso.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_piso.sv
// Parallel-in serial-out converter: a NUM_STAGES-element word is emitted element 0 first
// over a valid/ready stream. Optional macro PIPELINE_PISO_BACK_TO_BACK_EN allows bubble-free reloads.
module pipeline_piso #(
  parameter int unsigned           DATA_WIDTH = 1,
  parameter int unsigned           NUM_STAGES = 4,
  parameter logic [DATA_WIDTH-1:0] POR_VALUE  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] load_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last
);

  localparam int unsigned WordW = NUM_STAGES * DATA_WIDTH;
  localparam int unsigned CntW  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_STAGES - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_next;
  logic [WordW-1:0]      word_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  load_acc;
  logic                  beat_acc;
  logic                  b2b_ok;

`ifdef PIPELINE_PISO_BACK_TO_BACK_EN
  // Reload on the edge the last beat drains; combinational from out_ready.
  assign b2b_ok = out_last_q & out_ready;
`else
  assign b2b_ok = 1'b0;
`endif

  assign load_ready = ~reset & ((state_q == StIdle) | b2b_ok);
  assign load_acc   = load_valid & load_ready;
  assign beat_acc   = out_valid_q & out_ready;
  assign cnt_next   = cnt_q + CntW'(1);

  // word_q holds the not-yet-presented elements, next one in the low bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= POR_VALUE;
    end else if (load_acc) begin
      state_q     <= StShift;
      cnt_q       <= '0;
      word_q      <= load_data >> DATA_WIDTH;
      out_valid_q <= 1'b1;
      out_last_q  <= (NUM_STAGES == 1);
      out_data_q  <= load_data[DATA_WIDTH-1:0];
    end else if (beat_acc) begin
      if (cnt_q == LastCnt) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        cnt_q      <= cnt_next;
        word_q     <= word_q >> DATA_WIDTH;
        out_data_q <= word_q[DATA_WIDTH-1:0];
        out_last_q <= (cnt_next == LastCnt);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipeline_piso.sv
// Directed self-checking bench for pipeline_piso: a 4x8 instance and a 1x8 instance.
// Expectations follow PIPELINE_PISO_BACK_TO_BACK_EN when it is defined.
module tb_pipeline_piso;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_ready, out_valid, out_ready, out_last;
  logic [31:0] load_data;
  logic [7:0]  out_data;
  logic        s_load_valid, s_load_ready, s_out_valid, s_out_ready, s_out_last;
  logic [7:0]  s_load_data, s_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_piso #(
    .DATA_WIDTH(8),
    .NUM_STAGES(4),
    .POR_VALUE (8'hE7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  pipeline_piso #(
    .DATA_WIDTH(8),
    .NUM_STAGES(1),
    .POR_VALUE (8'h00)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .load_valid(s_load_valid),
    .load_ready(s_load_ready),
    .load_data (s_load_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_last  (s_out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; out_ready = 1'b0;
    s_load_valid = 1'b0; s_load_data = '0; s_out_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_last, out_data} !== {1'b0, 1'b0, 8'hE7}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b l=%b d=%h, want v=0 l=0 d=e7",
               out_valid, out_last, out_data);
    end
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_load_ready_low: got %b want 0", load_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (load_ready !== 1'b1 || s_load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_load_ready_high: got %b/%b want 1/1", load_ready, s_load_ready);
    end
  endtask

  task automatic test_basic_order();
    logic [7:0] ed [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    logic       ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_valid = 1'b1; load_data = 32'h44332211; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_last, out_data} !== {ev[i], el[i], ed[i]}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                 i, out_valid, out_last, out_data, ev[i], el[i], ed[i]);
      end
    end
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load_ready_after: got %b want 1", load_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [8] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
    logic       ev [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       el [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_valid = 1'b1; load_data = 32'h44332211; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      load_valid = 1'b0;
      load_data  = 32'hDEADBEEF;
      out_ready  = !(i >= 1 && i <= 3);
      n_checks++;
      if ({out_valid, out_last, out_data} !== {ev[i], el[i], ed[i]}) begin
        n_fail++;
        $display("FAIL backpressure_cycle%0d: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                 i, out_valid, out_last, out_data, ev[i], el[i], ed[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
`ifdef PIPELINE_PISO_BACK_TO_BACK_EN
    localparam int N = 9;
    localparam int DropAt = 4;
    logic [7:0] ed [N] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    logic       ev [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       el [N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    localparam int N = 10;
    localparam int DropAt = 5;
    logic [7:0] ed [N] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h88};
    logic       ev [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       el [N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    load_valid = 1'b1; load_data = 32'h44332211; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      if (i == 0) load_data = 32'h88776655;
      if (i == DropAt) load_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_last, out_data} !== {ev[i], el[i], ed[i]}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got v=%b l=%b d=%h, want v=%b l=%b d=%h",
                 i, out_valid, out_last, out_data, ev[i], el[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_valid = 1'b1; load_data = 32'h44332211; out_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    n_checks++;
    if (out_data !== 8'h22) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got d=%h want 22", out_data);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_last, out_data, load_ready} !== {1'b0, 1'b0, 8'hE7, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got v=%b l=%b d=%h rdy=%b, want v=0 l=0 d=e7 rdy=0",
               out_valid, out_last, out_data, load_ready);
    end
    reset = 1'b0; load_valid = 1'b1; load_data = 32'hDDCCBBAA;
    #1;
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b want 1", load_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      load_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (i == 3), ed[i]}) begin
        n_fail++;
        $display("FAIL reset_mid_word%0d: got v=%b l=%b d=%h, want v=1 l=%b d=%h",
                 i, out_valid, out_last, out_data, (i == 3), ed[i]);
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_single_stage();
    s_load_valid = 1'b1; s_load_data = 8'h5A; s_out_ready = 1'b0;
    tick();
    s_load_data = 8'h33;
    n_checks++;
    if ({s_out_valid, s_out_last, s_out_data} !== {1'b1, 1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL single_first: got v=%b l=%b d=%h, want v=1 l=1 d=5a",
               s_out_valid, s_out_last, s_out_data);
    end
    tick();
    n_checks++;
    if ({s_out_valid, s_out_last, s_out_data, s_load_ready} !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL single_hold: got v=%b l=%b d=%h rdy=%b, want v=1 l=1 d=5a rdy=0",
               s_out_valid, s_out_last, s_out_data, s_load_ready);
    end
    s_load_valid = 1'b0; s_load_data = 8'h77; s_out_ready = 1'b1;
    tick();
    n_checks++;
    if ({s_out_valid, s_out_last, s_out_data} !== {1'b0, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL single_idle1: got v=%b l=%b d=%h, want v=0 l=0 d=5a",
               s_out_valid, s_out_last, s_out_data);
    end
    s_load_valid = 1'b1; s_load_data = 8'hA5;
    tick();
    s_load_valid = 1'b0; s_load_data = 8'h99;
    n_checks++;
    if ({s_out_valid, s_out_last, s_out_data} !== {1'b1, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_second: got v=%b l=%b d=%h, want v=1 l=1 d=a5",
               s_out_valid, s_out_last, s_out_data);
    end
    tick();
    n_checks++;
    if ({s_out_valid, s_out_last, s_out_data} !== {1'b0, 1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_idle2: got v=%b l=%b d=%h, want v=0 l=0 d=a5",
               s_out_valid, s_out_last, s_out_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_single_stage();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
